eeprom_access_arbiter: RTL and testbench

EEPROM_ACCESS_ARBITER -- requirements
Module: eeprom_access_arbiter

---
 rtl/eeprom_arb_pkg.sv | 23 ++
 rtl/eeprom_access_arbiter_if.sv | 53 +++++
 rtl/eeprom_rr_arb2.sv | 26 ++
 rtl/eeprom_access_arbiter.sv | 144 ++++++++++++++
 tb/tb_eeprom_access_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/eeprom_arb_pkg.sv
// Shared types for the two-requester EEPROM access arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package eeprom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WR_WAIT = 2'd2
    } arb_state_e;

    // Requester index: 0 = r0, 1 = r1.
    typedef logic req_idx_t;

    // Pointing "last grant" at r1 out of reset makes r0 win the first tie.
    localparam req_idx_t LAST_GRANT_RST = 1'b1;

    // One-hot two-bit grant to requester index.
    function automatic req_idx_t grant_to_idx(input logic [1:0] grant);
        return req_idx_t'(grant[1]);
    endfunction

endpackage

// File: rtl/eeprom_access_arbiter_if.sv
// Requester and array-side signals of the EEPROM access arbiter.
// Latency: n/a (signal bundle).
// Backpressure: rN_valid/rN_ready handshake per requester; array port has none.
interface eeprom_access_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              r0_valid;
    logic              r0_ready;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_rvalid;

    logic              r1_valid;
    logic              r1_ready;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        output r0_ready, r0_rdata, r0_rvalid,
        input  r1_valid, r1_we, r1_addr, r1_wdata,
        output r1_ready, r1_rdata, r1_rvalid,
        output mem_addr, mem_din, mem_we,
        input  mem_dout,
        output busy
    );

    // Requesters plus the array model.
    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        input  r0_ready, r0_rdata, r0_rvalid,
        output r1_valid, r1_we, r1_addr, r1_wdata,
        input  r1_ready, r1_rdata, r1_rvalid,
        input  mem_addr, mem_din, mem_we,
        output mem_dout,
        input  busy
    );

endinterface

// File: rtl/eeprom_rr_arb2.sv
// Two-way round-robin grant: one-hot winner among valid requesters.
// Latency: combinational.
// Backpressure: grant is forced to zero while enable is low.
module eeprom_rr_arb2
    import eeprom_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_idx_t   last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Serialises two requesters onto one EEPROM array port with write-cycle busy time.
// Latency: read accepted at T returns rvalid at T+2; write strobes at T+1, idle after WR_CYCLES.
// Backpressure: rN_ready only in IDLE; nothing is accepted while busy.
module eeprom_access_arbiter
    import eeprom_arb_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 16
)(
    input  logic                    clk,
    input  logic                    rst_n,
    eeprom_access_arbiter_if.slave  bus
);

    localparam int CNT_W    = (WR_CYCLES > 0) ? $clog2(WR_CYCLES + 1) : 1;
    localparam int CNT_LOAD = (WR_CYCLES > 0) ? WR_CYCLES - 1 : 0;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_idx_t          last_q, last_d;
    req_idx_t          idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic [1:0]        grant;
    logic              accept;
    req_idx_t          win_idx;

    // Grants are only offered in IDLE and never while reset is asserted.
    eeprom_rr_arb2 u_rr_arb (
        .valid      ({bus.r1_valid, bus.r0_valid}),
        .last_grant (last_q),
        .enable     (rst_n && (state_q == IDLE)),
        .grant      (grant)
    );

    assign accept  = |grant;
    assign win_idx = grant_to_idx(grant);

    // Next-state: latch the winner's request, sequence the array, count write busy time.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        idx_d     = idx_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = win_idx;
                    last_d  = win_idx;
                    we_d    = win_idx ? bus.r1_we    : bus.r0_we;
                    addr_d  = win_idx ? bus.r1_addr  : bus.r0_addr;
                    wdata_d = win_idx ? bus.r1_wdata : bus.r0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    if (WR_CYCLES > 0) begin
                        state_d = WR_WAIT;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                    if (idx_q == 1'b0) begin
                        rdata0_d  = bus.mem_dout;
                        rvalid0_d = 1'b1;
                    end else begin
                        rdata1_d  = bus.mem_dout;
                        rvalid1_d = 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= LAST_GRANT_RST;
            idx_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign bus.r0_ready  = grant[0];
    assign bus.r1_ready  = grant[1];
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;

    // Array port always shows the latched request; the strobe is gated by reset
    // so an aborted write never reaches the array.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = wdata_q;
    assign bus.mem_we    = rst_n && (state_q == ACCESS) && we_q;
    assign bus.busy      = rst_n && (state_q != IDLE);

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Directed bench for eeprom_access_arbiter: one instance with WR_CYCLES=16, one with 0.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: requesters hold valid until ready as each vector requires.
module tb_eeprom_access_arbiter;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_pass;

    eeprom_access_arbiter_if #(.ADDR_W(11), .DATA_W(8)) b ();
    eeprom_access_arbiter_if #(.ADDR_W(11), .DATA_W(8)) z ();

    eeprom_access_arbiter #(.ADDR_W(11), .DATA_W(8), .WR_CYCLES(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    eeprom_access_arbiter #(.ADDR_W(11), .DATA_W(8), .WR_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (z.slave)
    );

    // Array model: fixed contents, 0x5A at 0x123, otherwise low address byte ^ 0xC3.
    function automatic logic [7:0] arr(input logic [10:0] a);
        return (a == 11'h123) ? 8'h5A : (a[7:0] ^ 8'hC3);
    endfunction

    assign b.mem_dout = arr(b.mem_addr);
    assign z.mem_dout = arr(z.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] bb_data [3];
        bb_data[0] = 8'hE3;
        bb_data[1] = 8'hE2;
        bb_data[2] = 8'hE1;
        n_chk  = 0;
        n_pass = 0;

        b.r0_valid = 0; b.r0_we = 0; b.r0_addr = '0; b.r0_wdata = '0;
        b.r1_valid = 0; b.r1_we = 0; b.r1_addr = '0; b.r1_wdata = '0;
        z.r0_valid = 0; z.r0_we = 0; z.r0_addr = '0; z.r0_wdata = '0;
        z.r1_valid = 0; z.r1_we = 0; z.r1_addr = '0; z.r1_wdata = '0;
        rst_n = 0;

        // Reset: ready stays low even with a valid request present.
        b.r0_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_r0_ready", b.r0_ready, 0);
        check("rst_busy", b.busy, 0);
        check("rst_mem_we", b.mem_we, 0);
        check("rst_r0_rvalid", b.r0_rvalid, 0);
        check("rst_r0_rdata", b.r0_rdata, 0);
        check("rst_r1_rdata", b.r1_rdata, 0);
        check("rst_z_busy", z.busy, 0);
        @(negedge clk);
        b.r0_valid = 0;
        rst_n = 1;

        // Single read by r0 at 0x123.
        @(negedge clk);
        b.r0_valid = 1; b.r0_we = 0; b.r0_addr = 11'h123;
        #1;
        check("rd_r0_ready", b.r0_ready, 1);
        check("rd_r1_ready", b.r1_ready, 0);
        @(negedge clk);
        b.r0_valid = 0; b.r0_addr = 11'h000;
        #1;
        check("rd_busy_t1", b.busy, 1);
        check("rd_mem_addr", b.mem_addr, 11'h123);
        check("rd_mem_we", b.mem_we, 0);
        check("rd_rvalid_t1", b.r0_rvalid, 0);
        @(negedge clk);
        #1;
        check("rd_rvalid_t2", b.r0_rvalid, 1);
        check("rd_rdata", b.r0_rdata, 8'h5A);
        check("rd_r1_rvalid", b.r1_rvalid, 0);
        check("rd_r1_rdata", b.r1_rdata, 0);
        check("rd_busy_t2", b.busy, 0);
        @(negedge clk);
        #1;
        check("rd_rvalid_t3", b.r0_rvalid, 0);
        check("rd_rdata_hold", b.r0_rdata, 8'h5A);

        // r1 writes 0xA5 to 0x7FF; r0 waits from T+2 and is taken at T+18.
        @(negedge clk);
        b.r1_valid = 1; b.r1_we = 1; b.r1_addr = 11'h7FF; b.r1_wdata = 8'hA5;
        #1;
        check("wr_r1_ready", b.r1_ready, 1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b.r1_valid = 0; b.r1_addr = 11'h000; b.r1_wdata = 8'h00;
            end
            if (k == 2) begin
                b.r0_valid = 1; b.r0_we = 0; b.r0_addr = 11'h010;
            end
            #1;
            check($sformatf("wr_mem_we_%0d", k), b.mem_we, (k == 1));
            check($sformatf("wr_busy_%0d", k), b.busy, (k <= 17));
            check($sformatf("wr_r0_ready_%0d", k), b.r0_ready, (k == 18));
            check($sformatf("wr_r1_rvalid_%0d", k), b.r1_rvalid, 0);
            if (k == 1) begin
                check("wr_mem_addr", b.mem_addr, 11'h7FF);
                check("wr_mem_din", b.mem_din, 8'hA5);
            end
        end
        @(negedge clk);
        b.r0_valid = 0;
        #1;
        check("wr_rd_busy", b.busy, 1);
        check("wr_rd_addr", b.mem_addr, 11'h010);
        @(negedge clk);
        #1;
        check("wr_rd_rvalid", b.r0_rvalid, 1);
        check("wr_rd_rdata", b.r0_rdata, 8'hD3);
        check("wr_r1_rdata", b.r1_rdata, 0);

        // Tie from reset: r0, r1, r0, r1.
        rst_n = 0;
        b.r0_valid = 1; b.r0_we = 0; b.r0_addr = 11'h001;
        b.r1_valid = 1; b.r1_we = 0; b.r1_addr = 11'h002;
        repeat (2) @(negedge clk);
        #1;
        check("tie_rst_r0_ready", b.r0_ready, 0);
        check("tie_rst_r1_ready", b.r1_ready, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 8) begin
                b.r0_valid = 0; b.r1_valid = 0;
            end
            #1;
            check($sformatf("tie_r0_ready_%0d", i), b.r0_ready,
                  (i < 8) && (i % 2 == 0) && ((i / 2) % 2 == 0));
            check($sformatf("tie_r1_ready_%0d", i), b.r1_ready,
                  (i < 8) && (i % 2 == 0) && ((i / 2) % 2 == 1));
            if (i >= 2 && i % 2 == 0) begin
                if (((i / 2 - 1) % 2) == 0) begin
                    check($sformatf("tie_r0_rvalid_%0d", i), b.r0_rvalid, 1);
                    check($sformatf("tie_r0_rdata_%0d", i), b.r0_rdata, 8'hC2);
                    check($sformatf("tie_r1_rvalid_%0d", i), b.r1_rvalid, 0);
                end else begin
                    check($sformatf("tie_r1_rvalid_%0d", i), b.r1_rvalid, 1);
                    check($sformatf("tie_r1_rdata_%0d", i), b.r1_rdata, 8'hC1);
                    check($sformatf("tie_r0_rvalid_%0d", i), b.r0_rvalid, 0);
                end
            end
        end

        // Back-to-back reads by r0 at 0x020, 0x021, 0x022.
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            b.r0_valid = (i <= 4);
            b.r0_addr  = 11'h020 + 11'(i / 2);
            #1;
            check($sformatf("b2b_ready_%0d", i), b.r0_ready, (i <= 4) && (i % 2 == 0));
            check($sformatf("b2b_rvalid_%0d", i), b.r0_rvalid, (i >= 2) && (i % 2 == 0));
            if (i >= 2 && i % 2 == 0)
                check($sformatf("b2b_rdata_%0d", i), b.r0_rdata, bb_data[i / 2 - 1]);
        end

        // Reset during WR_WAIT (counter 5) after an r0 write.
        @(negedge clk);
        b.r0_valid = 1; b.r0_we = 1; b.r0_addr = 11'h055; b.r0_wdata = 8'h11;
        #1;
        check("abort_r0_ready", b.r0_ready, 1);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) b.r0_valid = 0;
            if (k == 12) rst_n = 0;
            #1;
            if (k >= 2 && k <= 11) begin
                check($sformatf("abort_busy_%0d", k), b.busy, 1);
                check($sformatf("abort_we_%0d", k), b.mem_we, 0);
            end
        end
        check("abort_busy_in_rst", b.busy, 0);
        @(negedge clk);
        rst_n = 1;
        b.r0_valid = 1; b.r0_we = 0; b.r0_addr = 11'h030;
        b.r1_valid = 1; b.r1_we = 0; b.r1_addr = 11'h031;
        #1;
        check("abort_busy_after", b.busy, 0);
        check("abort_we_after", b.mem_we, 0);
        check("abort_tie_r0", b.r0_ready, 1);
        check("abort_tie_r1", b.r1_ready, 0);
        @(negedge clk);
        b.r0_valid = 0; b.r1_valid = 0;
        #1;
        check("abort_rd_we", b.mem_we, 0);
        check("abort_rd_busy", b.busy, 1);
        @(negedge clk);
        #1;
        check("abort_rd_rvalid", b.r0_rvalid, 1);
        check("abort_rd_rdata", b.r0_rdata, 8'hF3);
        @(negedge clk);
        #1;
        check("abort_idle_busy", b.busy, 0);
        check("abort_idle_rvalid", b.r0_rvalid, 0);

        // WR_CYCLES=0: write at T, strobe at T+1, next accept at T+2.
        @(negedge clk);
        z.r1_valid = 1; z.r1_we = 1; z.r1_addr = 11'h100; z.r1_wdata = 8'h77;
        #1;
        check("w0_r1_ready", z.r1_ready, 1);
        @(negedge clk);
        z.r1_valid = 0;
        z.r0_valid = 1; z.r0_we = 0; z.r0_addr = 11'h005;
        #1;
        check("w0_mem_we", z.mem_we, 1);
        check("w0_mem_addr", z.mem_addr, 11'h100);
        check("w0_mem_din", z.mem_din, 8'h77);
        check("w0_busy_t1", z.busy, 1);
        check("w0_r0_ready_t1", z.r0_ready, 0);
        @(negedge clk);
        #1;
        check("w0_busy_t2", z.busy, 0);
        check("w0_we_t2", z.mem_we, 0);
        check("w0_r0_ready_t2", z.r0_ready, 1);
        @(negedge clk);
        z.r0_valid = 0;
        #1;
        check("w0_rd_busy", z.busy, 1);
        check("w0_rd_we", z.mem_we, 0);
        @(negedge clk);
        #1;
        check("w0_rd_rvalid", z.r0_rvalid, 1);
        check("w0_rd_rdata", z.r0_rdata, 8'hC6);
        check("w0_r1_rvalid", z.r1_rvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
